// File: rtl/relogio_xadrez_mod.sv
// Two-player chess clock: one saturating elapsed-time counter per player,
// a shared tick prescaler, per-move bonus and a four-state control FSM.
module relogio_xadrez_mod #(
  parameter int M   = 6000,
  parameter int N   = 13,
  parameter int D   = 50,
  parameter int DIV = 500000,
  parameter int DW  = 19
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera_s,
  input  logic         inicia,
  input  logic         pausa,
  input  logic         jogada,
  output logic [N-1:0] Q_a,
  output logic [N-1:0] Q_b,
  output logic         vez,
  output logic         fim_a,
  output logic         fim_b,
  output logic [1:0]   estado
);

  typedef enum logic [1:0] {
    PARADO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSADO  = 2'b10,
    ESGOTADO = 2'b11
  } state_t;

  localparam logic [N:0]    LAST     = (N+1)'(M - 1);
  localparam logic [N-1:0]  LAST_Q   = N'(M - 1);
  localparam logic [N:0]    BONUS    = (N+1)'(D);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  state_t        state, state_next;
  logic [N-1:0]  qa_next, qb_next, updated;
  logic [N:0]    active, stepped;
  logic [DW-1:0] presc, presc_next;
  logic          vez_next, tick;

  // Only the active player's counter is ever rewritten; the wide
  // intermediate keeps Q+1 and Q-D from wrapping.
  always_comb begin
    state_next = state;
    qa_next    = Q_a;
    qb_next    = Q_b;
    vez_next   = vez;
    presc_next = presc;
    active     = vez ? {1'b0, Q_b} : {1'b0, Q_a};
    tick       = (presc == DIV_LAST);
    stepped    = tick ? active + 1'b1 : active;
    updated    = active[N-1:0];

    case (state)
      PARADO: if (inicia) state_next = CONTANDO;
      CONTANDO: begin
        if (pausa) begin
          state_next = PAUSADO;
        end else if (tick && stepped == LAST) begin
          updated    = LAST_Q;
          state_next = ESGOTADO;
          presc_next = '0;
        end else if (jogada) begin
          updated    = (stepped >= BONUS) ? N'(stepped - BONUS) : '0;
          vez_next   = ~vez;
          presc_next = '0;
        end else begin
          updated    = stepped[N-1:0];
          presc_next = tick ? '0 : presc + 1'b1;
        end
      end
      PAUSADO: if (inicia) state_next = CONTANDO;
      default: ;
    endcase

    if (vez) qb_next = updated;
    else     qa_next = updated;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= PARADO;
      Q_a   <= '0;
      Q_b   <= '0;
      vez   <= 1'b0;
      presc <= '0;
    end else if (zera_s) begin
      state <= PARADO;
      Q_a   <= '0;
      Q_b   <= '0;
      vez   <= 1'b0;
      presc <= '0;
    end else begin
      state <= state_next;
      Q_a   <= qa_next;
      Q_b   <= qb_next;
      vez   <= vez_next;
      presc <= presc_next;
    end
  end

  assign estado = state;
  assign fim_a  = (Q_a == LAST_Q);
  assign fim_b  = (Q_b == LAST_Q);

endmodule

// File: tb/tb_relogio_xadrez_mod.sv
// Directed bench for the chess clock: main instance M=10,N=4,D=3,DIV=4,
// plus a DIV=1,D=0 instance sharing the same inputs.
module tb_relogio_xadrez_mod;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       zera_s = 1'b0, inicia = 1'b0, pausa = 1'b0, jogada = 1'b0;
  logic [3:0] q_a, q_b, q6_a, q6_b;
  logic       vez, fim_a, fim_b, vez6, fim6_a, fim6_b;
  logic [1:0] estado, estado6;
  int         checks = 0;
  int         failures = 0;

  relogio_xadrez_mod #(.M(10), .N(4), .D(3), .DIV(4), .DW(2)) dut (
    .clock(clock), .reset(reset), .zera_s(zera_s), .inicia(inicia),
    .pausa(pausa), .jogada(jogada), .Q_a(q_a), .Q_b(q_b), .vez(vez),
    .fim_a(fim_a), .fim_b(fim_b), .estado(estado)
  );

  relogio_xadrez_mod #(.M(10), .N(4), .D(0), .DIV(1), .DW(1)) dut6 (
    .clock(clock), .reset(reset), .zera_s(zera_s), .inicia(inicia),
    .pausa(pausa), .jogada(jogada), .Q_a(q6_a), .Q_b(q6_b), .vez(vez6),
    .fim_a(fim6_a), .fim_b(fim6_b), .estado(estado6)
  );

  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    zera_s = 0; inicia = 0; pausa = 0; jogada = 0;
    reset = 1;
    #2;
    reset = 0;
  endtask

  task automatic start();
    inicia = 1;
    step(1);
    inicia = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (q_a !== 4'd0) begin failures++; $display("[TB] FAIL reset_qa got=%0d exp=0", q_a); end
    checks++; if (q_b !== 4'd0) begin failures++; $display("[TB] FAIL reset_qb got=%0d exp=0", q_b); end
    checks++; if (vez !== 1'b0) begin failures++; $display("[TB] FAIL reset_vez got=%0b exp=0", vez); end
    checks++; if (estado !== 2'b00) begin failures++; $display("[TB] FAIL reset_estado got=%0b exp=00", estado); end
    checks++; if ({fim_a, fim_b} !== 2'b00) begin failures++; $display("[TB] FAIL reset_fim got=%0b exp=00", {fim_a, fim_b}); end
  endtask

  task automatic test_timeout();
    do_reset();
    start();
    checks++; if (estado !== 2'b01) begin failures++; $display("[TB] FAIL to_start_estado got=%0b exp=01", estado); end
    step(3);
    checks++; if (q_a !== 4'd0) begin failures++; $display("[TB] FAIL to_before_tick got=%0d exp=0", q_a); end
    step(1);
    checks++; if (q_a !== 4'd1) begin failures++; $display("[TB] FAIL to_first_tick got=%0d exp=1", q_a); end
    step(31);
    checks++; if (q_a !== 4'd8 || fim_a !== 1'b0) begin failures++; $display("[TB] FAIL to_q8 got=%0d/%0b exp=8/0", q_a, fim_a); end
    step(1);
    checks++; if (q_a !== 4'd9 || fim_a !== 1'b1) begin failures++; $display("[TB] FAIL to_q9 got=%0d/%0b exp=9/1", q_a, fim_a); end
    checks++; if (estado !== 2'b11 || q_b !== 4'd0 || fim_b !== 1'b0) begin failures++; $display("[TB] FAIL to_estado got=%0b qb=%0d exp=11 qb=0", estado, q_b); end
    inicia = 1; jogada = 1;
    step(4);
    inicia = 0; jogada = 0;
    checks++; if (q_a !== 4'd9 || vez !== 1'b0 || estado !== 2'b11) begin failures++; $display("[TB] FAIL to_frozen got=%0d/%0b/%0b exp=9/0/11", q_a, vez, estado); end
  endtask

  task automatic test_jogada();
    do_reset();
    start();
    step(20);
    checks++; if (q_a !== 4'd5) begin failures++; $display("[TB] FAIL jg_q5 got=%0d exp=5", q_a); end
    jogada = 1;
    step(1);
    jogada = 0;
    checks++; if (q_a !== 4'd2 || vez !== 1'b1) begin failures++; $display("[TB] FAIL jg_bonus got=%0d/%0b exp=2/1", q_a, vez); end
    step(3);
    checks++; if (q_b !== 4'd0) begin failures++; $display("[TB] FAIL jg_qb_early got=%0d exp=0", q_b); end
    step(1);
    checks++; if (q_b !== 4'd1 || q_a !== 4'd2) begin failures++; $display("[TB] FAIL jg_qb1 got=%0d qa=%0d exp=1 qa=2", q_b, q_a); end
    step(4);
    checks++; if (q_b !== 4'd2) begin failures++; $display("[TB] FAIL jg_qb2 got=%0d exp=2", q_b); end
    jogada = 1;
    step(1);
    jogada = 0;
    checks++; if (q_b !== 4'd0 || vez !== 1'b0 || q_a !== 4'd2) begin failures++; $display("[TB] FAIL jg_saturate got=%0d/%0b qa=%0d exp=0/0 qa=2", q_b, vez, q_a); end
  endtask

  task automatic test_pausa();
    do_reset();
    start();
    step(14);
    checks++; if (q_a !== 4'd3) begin failures++; $display("[TB] FAIL pa_q3 got=%0d exp=3", q_a); end
    pausa = 1;
    step(1);
    pausa = 0;
    step(20);
    checks++; if (q_a !== 4'd3 || estado !== 2'b10) begin failures++; $display("[TB] FAIL pa_frozen got=%0d/%0b exp=3/10", q_a, estado); end
    start();
    checks++; if (estado !== 2'b01) begin failures++; $display("[TB] FAIL pa_resume got=%0b exp=01", estado); end
    step(1);
    checks++; if (q_a !== 4'd3) begin failures++; $display("[TB] FAIL pa_phase_a got=%0d exp=3", q_a); end
    step(1);
    checks++; if (q_a !== 4'd4) begin failures++; $display("[TB] FAIL pa_phase_b got=%0d exp=4", q_a); end
    pausa = 1; inicia = 1;
    step(1);
    pausa = 0; inicia = 0;
    checks++; if (estado !== 2'b10 || q_a !== 4'd4) begin failures++; $display("[TB] FAIL pa_priority got=%0b/%0d exp=10/4", estado, q_a); end
  endtask

  task automatic test_tick_jogada();
    do_reset();
    start();
    step(19);
    jogada = 1;
    step(1);
    jogada = 0;
    checks++; if (q_a !== 4'd2 || vez !== 1'b1 || q_b !== 4'd0) begin failures++; $display("[TB] FAIL tj_bonus got=%0d/%0b qb=%0d exp=2/1 qb=0", q_a, vez, q_b); end
    do_reset();
    start();
    step(35);
    checks++; if (q_a !== 4'd8) begin failures++; $display("[TB] FAIL tj_q8 got=%0d exp=8", q_a); end
    jogada = 1;
    step(1);
    jogada = 0;
    checks++; if (q_a !== 4'd9 || estado !== 2'b11 || vez !== 1'b0) begin failures++; $display("[TB] FAIL tj_timeout got=%0d/%0b/%0b exp=9/11/0", q_a, estado, vez); end
  endtask

  task automatic test_clear();
    do_reset();
    start();
    step(12);
    jogada = 1;
    step(1);
    jogada = 0;
    step(4);
    checks++; if (q_b !== 4'd1 || vez !== 1'b1) begin failures++; $display("[TB] FAIL cl_setup got=%0d/%0b exp=1/1", q_b, vez); end
    reset = 1;
    #1;
    checks++; if (q_b !== 4'd0 || vez !== 1'b0 || estado !== 2'b00) begin failures++; $display("[TB] FAIL cl_async got=%0d/%0b/%0b exp=0/0/00", q_b, vez, estado); end
    reset = 0;
    #1;
    checks++; if (q_a !== 4'd0 || estado !== 2'b00) begin failures++; $display("[TB] FAIL cl_async_hold got=%0d/%0b exp=0/00", q_a, estado); end
    step(1);
    start();
    step(36);
    checks++; if (estado !== 2'b11) begin failures++; $display("[TB] FAIL cl_esgotado got=%0b exp=11", estado); end
    zera_s = 1;
    step(1);
    zera_s = 0;
    checks++; if (estado !== 2'b00 || q_a !== 4'd0 || q_b !== 4'd0 || fim_a !== 1'b0) begin failures++; $display("[TB] FAIL cl_zera got=%0b/%0d/%0d exp=00/0/0", estado, q_a, q_b); end
    step(4);
    checks++; if (q_a !== 4'd0 || estado !== 2'b00) begin failures++; $display("[TB] FAIL cl_zera_idle got=%0d/%0b exp=0/00", q_a, estado); end
  endtask

  task automatic test_div1();
    do_reset();
    jogada = 1;
    step(3);
    jogada = 0;
    checks++; if (estado6 !== 2'b00 || q6_a !== 4'd0 || vez6 !== 1'b0) begin failures++; $display("[TB] FAIL d1_parado got=%0b/%0d/%0b exp=00/0/0", estado6, q6_a, vez6); end
    checks++; if (estado !== 2'b00 || vez !== 1'b0) begin failures++; $display("[TB] FAIL d1_parado_main got=%0b/%0b exp=00/0", estado, vez); end
    start();
    checks++; if (q6_a !== 4'd0 || estado6 !== 2'b01) begin failures++; $display("[TB] FAIL d1_start got=%0d/%0b exp=0/01", q6_a, estado6); end
    step(2);
    checks++; if (q6_a !== 4'd2) begin failures++; $display("[TB] FAIL d1_count got=%0d exp=2", q6_a); end
    jogada = 1;
    step(1);
    jogada = 0;
    checks++; if (q6_a !== 4'd3 || vez6 !== 1'b1 || q6_b !== 4'd0) begin failures++; $display("[TB] FAIL d1_jogada got=%0d/%0b qb=%0d exp=3/1 qb=0", q6_a, vez6, q6_b); end
    step(1);
    checks++; if (q6_b !== 4'd1 || q6_a !== 4'd3) begin failures++; $display("[TB] FAIL d1_qb got=%0d qa=%0d exp=1 qa=3", q6_b, q6_a); end
  endtask

  initial begin
    #3;
    test_reset();
    test_timeout();
    test_jogada();
    test_pausa();
    test_tick_jogada();
    test_clear();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
